sr_cmd_conditioner: RTL
=======================

SR_CMD_CONDITIONER -- requirements
Module: sr_cmd_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4, consecutive stable synchronized cycles required to accept a level change; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 set_in  input  1  raw asynchronous set button/command, active-high.
REQ-005 reset_in  input  1  raw asynchronous reset button/command, active-high.
REQ-006 s  output  1  registered set pulse to the downstream gated SR flip-flop.
REQ-007 r  output  1  registered reset pulse to the downstream gated SR flip-flop.
REQ-008 busy  output  1  high while a command is issued or awaiting release.

Function
REQ-009 Each raw input SHALL pass through a 2-flop synchronizer.
REQ-010 Each channel SHALL have a debounce counter: it increments while the synchronized value differs from the debounced level, and clears on any cycle they match.
REQ-011 The debounced level SHALL toggle, and its counter clear, on the edge where the counter would reach DEBOUNCE_CYCLES.
REQ-012 Request = debounced level rising, i.e. debounced high and previous debounced low; the request lasts one cycle.
REQ-013 FSM states SHALL be IDLE, SET_PULSE, RST_PULSE, WAIT_REL.
REQ-014 IDLE: set request only -> SET_PULSE; reset request only -> RST_PULSE; both in the same cycle -> stay IDLE, no pulse.
REQ-015 SET_PULSE and RST_PULSE SHALL last exactly one cycle, then go to WAIT_REL.
REQ-016 WAIT_REL -> IDLE when both debounced levels are low.
REQ-017 Requests arriving outside IDLE SHALL be discarded, not queued.
REQ-018 s SHALL be high exactly in SET_PULSE; r exactly in RST_PULSE; s and r SHALL never be high together.
REQ-019 busy SHALL be high in SET_PULSE, RST_PULSE and WAIT_REL.
REQ-020 Latency: with raw input high from edge 1 on, the debounced level SHALL rise at edge DEBOUNCE_CYCLES+2 and s/r SHALL rise at edge DEBOUNCE_CYCLES+3.
REQ-021 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no pulse.

Reset
REQ-022 When rst is low: synchronizers, debounced levels, counters and previous-level registers clear to 0; FSM goes to IDLE; s, r, busy are 0 (and conflict is 0 when compiled in).
REQ-023 Reset asserted mid-pulse SHALL drop s/r at once, asynchronously.
REQ-024 Inputs held high through reset release SHALL generate a request after debounce, since the debounced level restarts at 0.

Configuration
REQ-025 With SR_CONFLICT_FLAG_EN defined, the block SHALL add output port conflict (1 bit), a one-cycle pulse registered on the edge after simultaneous requests are seen in IDLE.
REQ-026 With SR_CONFLICT_FLAG_EN defined, it SHALL also add output conflict_cnt (8 bits), a saturating count of conflicts, cleared by reset.
REQ-027 Without SR_CONFLICT_FLAG_EN, neither port nor its logic SHALL exist; FSM behaviour is identical.

Structure
REQ-028 Shared package sr_cmd_pkg SHALL hold the FSM state enum and the debounce counter width constant, derived from the maximum DEBOUNCE_CYCLES.
REQ-029 Sub-module sr_debounce (synchronizer + counter + edge detect, one channel) SHALL be instantiated twice.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 Reset, then set_in high from edge 1 -> s high for exactly the cycle after edge 7; r stays 0; busy high from edge 7 until 7 edges after set_in falls.
REQ-031 reset_in pulse 3 cycles wide -> no r pulse, busy stays 0.
REQ-032 set_in and reset_in rise in the same cycle -> no s/r pulse; conflict pulses once and conflict_cnt=1 when SR_CONFLICT_FLAG_EN is defined.
REQ-033 set_in held, then reset_in raised while in WAIT_REL -> no r pulse; after both are released and debounced, a new reset_in press -> r pulse.
REQ-034 rst low during SET_PULSE -> s=0 immediately; after release, with inputs low, there is no spurious pulse.
REQ-035 Random glitch and bounce stream, checked by assertion -> s&r never 1; every pulse is exactly one cycle wide.

Source files
------------

// File: rtl/sr_cmd_pkg.sv
// Shared types and sizing for the SR command conditioner.
package sr_cmd_pkg;

   // Largest legal debounce length; sizes every channel's counter.
   localparam int unsigned DB_CYCLES_MAX  = 255;
   localparam int unsigned DB_CNT_W       = $clog2(DB_CYCLES_MAX + 1);
   localparam int unsigned CONFLICT_CNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_SET_PULSE = 2'd1,
      ST_RST_PULSE = 2'd2,
      ST_WAIT_REL  = 2'd3
   } sr_state_e;

endpackage

// File: rtl/sr_debounce.sv
// One input channel: 2-flop synchronizer, debounce counter, rising-edge request.
module sr_debounce
   import sr_cmd_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic req_c
);

   logic                sync1;
   logic                sync2;
   logic                prev_level;
   logic [DB_CNT_W-1:0] cnt;

   // Bring the asynchronous raw input into the clock domain.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Accept a level change only after it has been stable for DEBOUNCE_CYCLES cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         level <= 1'b0;
         cnt   <= '0;
      end else if (sync2 != level) begin
         if (cnt == DB_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + DB_CNT_W'(1);
         end
      end else begin
         cnt <= '0;
      end
   end

   // Previous debounced level for edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_level <= 1'b0;
      end else begin
         prev_level <= level;
      end
   end

   assign req_c = level & ~prev_level;

endmodule

// File: rtl/sr_cmd_conditioner.sv
// Conditions raw set/reset buttons into clean one-cycle s/r pulses for a gated SR flip-flop.
// Optional feature: define SR_CONFLICT_FLAG_EN to add the conflict / conflict_cnt outputs.
module sr_cmd_conditioner
   import sr_cmd_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic set_in,
   input  logic reset_in,
   output logic s,
   output logic r,
   output logic busy
`ifdef SR_CONFLICT_FLAG_EN
   ,
   output logic                      conflict,
   output logic [CONFLICT_CNT_W-1:0] conflict_cnt
`endif
);

   logic      set_level;
   logic      clr_level;
   logic      set_req_c;
   logic      clr_req_c;
   sr_state_e state;

   sr_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_db_set (
      .clk   (clk),
      .rst   (rst),
      .raw   (set_in),
      .level (set_level),
      .req_c (set_req_c)
   );

   sr_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_db_clr (
      .clk   (clk),
      .rst   (rst),
      .raw   (reset_in),
      .level (clr_level),
      .req_c (clr_req_c)
   );

   // Command FSM: one pulse per accepted request, then hold off until both buttons release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         s     <= 1'b0;
         r     <= 1'b0;
         busy  <= 1'b0;
      end else begin
         s <= 1'b0;
         r <= 1'b0;
         case (state)
            ST_IDLE: begin
               busy <= 1'b0;
               if (set_req_c && !clr_req_c) begin
                  state <= ST_SET_PULSE;
                  s     <= 1'b1;
                  busy  <= 1'b1;
               end else if (clr_req_c && !set_req_c) begin
                  state <= ST_RST_PULSE;
                  r     <= 1'b1;
                  busy  <= 1'b1;
               end
            end
            ST_SET_PULSE, ST_RST_PULSE: begin
               state <= ST_WAIT_REL;
               busy  <= 1'b1;
            end
            ST_WAIT_REL: begin
               if (!set_level && !clr_level) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  busy <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef SR_CONFLICT_FLAG_EN
   // Flag and count simultaneous set/reset requests seen while idle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         conflict     <= 1'b0;
         conflict_cnt <= '0;
      end else begin
         conflict <= (state == ST_IDLE) && set_req_c && clr_req_c;
         if ((state == ST_IDLE) && set_req_c && clr_req_c && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + CONFLICT_CNT_W'(1);
         end
      end
   end
`endif

endmodule
